// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and helpers for the data-memory access controller.
package dmem_access_ctrl_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned BYTE_OFS_W = 3;
  localparam int unsigned DMEM_WORDS = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  // One posted store: word-aligned byte address plus data.
  typedef struct packed {
    word_t addr;
    word_t data;
  } sb_entry_t;

  // True when the byte address is misaligned or beyond the memory.
  function automatic logic addr_bad(input word_t addr, input int unsigned mem_words);
    return (addr[BYTE_OFS_W-1:0] != '0) ||
           ((addr >> BYTE_OFS_W) >= WORD_W'(mem_words));
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_store_buffer.sv
// Circular store buffer with a youngest-match address lookup for forwarding.
module dmem_access_ctrl_store_buffer
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        push_entry,
  input  logic             pop,
  output sb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  input  word_t            lookup_addr,
  output logic             hit,
  output word_t            hit_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = entries[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Entry storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < cnt) && (entries[rd_ptr + PTR_W'(i)].addr == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = entries[rd_ptr + PTR_W'(i)].data;
      end
    end
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory initiator: load/store front end, posted store buffer, read FSM.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned SB_DEPTH  = 4,
  parameter int unsigned MEM_WORDS = DMEM_WORDS
) (
  input  logic              im_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              sb_empty
);

  localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

  state_t           state;
  logic             ready_q;
  logic             infl_valid;
  word_t            infl_addr;
  word_t            infl_data;

  sb_entry_t        push_entry;
  sb_entry_t        sb_head;
  logic             sb_full;
  logic             sb_none;
  logic [CNT_W-1:0] sb_count;
  logic             sb_hit;
  word_t            sb_hit_data;

  logic             accept;
  logic             req_bad;
  logic             push;
  logic             load_ok;
  logic             fwd_hit;
  word_t            fwd_data;
  logic             miss;
  logic             pop;
  logic [CNT_W-1:0] count_next;

  // Stores stall on a full buffer from the current count only, never on a same-cycle pop.
  assign req_ready = ready_q && !(req_write && sb_full);

  dmem_access_ctrl_store_buffer #(
    .DEPTH (SB_DEPTH)
  ) u_sb (
    .clk         (im_clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head        (sb_head),
    .full        (sb_full),
    .empty       (sb_none),
    .count       (sb_count),
    .lookup_addr (req_addr),
    .hit         (sb_hit),
    .hit_data    (sb_hit_data)
  );

  // Request decode, forwarding select and drain arbitration.
  always_comb begin
    push_entry.addr = req_addr;
    push_entry.data = req_wdata;
    accept          = req_valid && req_ready;
    req_bad         = addr_bad(req_addr, MEM_WORDS);
    push            = accept && req_write && !req_bad;
    load_ok         = accept && !req_write && !req_bad;
    fwd_hit         = 1'b0;
    fwd_data        = '0;
    // Buffered entries are younger than the in-flight write, so they win.
    if (sb_hit) begin
      fwd_hit  = 1'b1;
      fwd_data = sb_hit_data;
    end else if (infl_valid && (infl_addr == req_addr)) begin
      fwd_hit  = 1'b1;
      fwd_data = infl_data;
    end
    // Any older store to the same word forwards, so a miss never bypasses one.
    miss       = load_ok && !fwd_hit;
    pop        = (state == IDLE) && !sb_none && !miss;
    count_next = sb_count + CNT_W'(push) - CNT_W'(pop);
  end

  // FSM, response, in-flight write and memory-port registers.
  always_ff @(posedge im_clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      infl_valid <= 1'b0;
      infl_addr  <= '0;
      infl_data  <= '0;
      sb_empty   <= 1'b1;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= pop;
      infl_valid <= pop;
      sb_empty   <= (count_next == '0) && !pop;
      if (pop) begin
        mem_addr  <= sb_head.addr;
        mem_wdata <= sb_head.data;
        infl_addr <= sb_head.addr;
        infl_data <= sb_head.data;
      end
      case (state)
        IDLE: begin
          ready_q <= !miss;
          if (accept) begin
            rsp_valid <= !miss;
            rsp_err   <= req_bad;
            if (load_ok && fwd_hit) begin
              rsp_rdata <= fwd_data;
            end
            if (miss) begin
              mem_read <= 1'b1;
              mem_addr <= req_addr;
              state    <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          ready_q <= 1'b0;
          state   <= RD_DATA;
        end
        RD_DATA: begin
          ready_q   <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_rdata;
          state     <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl with a queue-based reference model.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WORDS = 32;

  logic        im_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        sb_empty;

  dmem_access_ctrl #(
    .SB_DEPTH  (DEPTH),
    .MEM_WORDS (WORDS)
  ) dut (
    .im_clk    (im_clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .sb_empty  (sb_empty)
  );

  always #5 im_clk = ~im_clk;

  function automatic logic [63:0] init_word(input int i);
    return (i == 3) ? 64'h1122 : 64'h1000 + 64'(i);
  endfunction

  // data_mem stand-in: registered read, write at end of the mem_write cycle.
  logic        preload;
  logic [63:0] dmem [WORDS];
  always @(posedge im_clk) begin
    if (preload) begin
      for (int i = 0; i < int'(WORDS); i++) dmem[i] <= init_word(i);
    end else begin
      if (mem_read)  mem_rdata <= dmem[mem_addr[7:3]];
      if (mem_write) dmem[mem_addr[7:3]] <= mem_wdata;
    end
  end

  // Reference model state.
  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } ent_t;
  ent_t        q[$];
  logic [63:0] ref_mem [WORDS];
  int          phase;
  bit          cool;
  bit          inf_v;
  logic [63:0] inf_a, inf_d;
  int          miss_word;
  bit          e_rv, e_err, e_mr, e_mw, e_empty;
  logic [63:0] e_rd, e_ma, e_wd;

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic bit model_ready(input bit w);
    return (phase == 0) && !cool && !(w && (q.size() == int'(DEPTH)));
  endfunction

  task automatic model_reset();
    q.delete();
    phase = 0; cool = 0; inf_v = 0; inf_a = '0; inf_d = '0; miss_word = 0;
    e_rv = 0; e_err = 0; e_mr = 0; e_mw = 0; e_empty = 1;
    e_rd = '0; e_ma = '0; e_wd = '0;
  endtask

  // One clock edge of the specified behaviour, applied to the request presented before it.
  task automatic model_step(input bit v, input bit w, input logic [63:0] a, input logic [63:0] d);
    bit rdy;
    bit do_pop;
    bit do_push;
    bit is_miss;
    rdy = model_ready(w);
    do_pop = 0; do_push = 0; is_miss = 0;
    if (inf_v) ref_mem[inf_a[7:3]] = inf_d;
    e_rv = 0; e_err = 0; e_rd = '0; e_mr = 0; e_mw = 0;
    if (phase == 1) begin
      phase = 2;
    end else if (phase == 2) begin
      e_rv = 1; e_rd = ref_mem[miss_word]; phase = 0; cool = 1;
    end else begin
      cool = 0;
      if (v && rdy) begin
        if ((a[2:0] != 3'd0) || ((a >> 3) >= 64'(WORDS))) begin
          e_rv = 1; e_err = 1;
        end else if (w) begin
          e_rv = 1; do_push = 1;
        end else begin
          bit found;
          logic [63:0] fd;
          found = 0; fd = '0;
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (!found && q[i].a == a) begin found = 1; fd = q[i].d; end
          end
          if (!found && inf_v && inf_a == a) begin found = 1; fd = inf_d; end
          if (found) begin
            e_rv = 1; e_rd = fd;
          end else begin
            is_miss = 1; phase = 1; miss_word = int'(a[7:3]); e_mr = 1; e_ma = a;
          end
        end
      end
      if (!is_miss && q.size() > 0) begin
        do_pop = 1; e_mw = 1; e_ma = q[0].a; e_wd = q[0].d;
      end
    end
    inf_v = do_pop;
    if (do_pop) begin
      inf_a = q[0].a; inf_d = q[0].d;
      void'(q.pop_front());
    end
    if (do_push) q.push_back('{a: a, d: d});
    e_empty = (q.size() == 0) && !inf_v;
  endtask

  task automatic check_outputs();
    chk1("rsp_valid", rsp_valid, e_rv);
    chk1("rsp_err", rsp_err, e_err);
    chk64("rsp_rdata", rsp_rdata, e_rd);
    chk1("mem_read", mem_read, e_mr);
    chk1("mem_write", mem_write, e_mw);
    chk1("sb_empty", sb_empty, e_empty);
    chk1("rw_exclusive", mem_read && mem_write, 1'b0);
    if (e_mr || e_mw) chk64("mem_addr", mem_addr, e_ma);
    if (e_mw) chk64("mem_wdata", mem_wdata, e_wd);
  endtask

  // Present a request for one cycle; starts and ends just after a falling edge.
  task automatic cycle(input bit v, input bit w, input logic [63:0] a, input logic [63:0] d);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d;
    #1;
    chk1("req_ready", req_ready, model_ready(w));
    @(posedge im_clk);
    model_step(v, w, a, d);
    @(negedge im_clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 64'h0, 64'h0);
  endtask

  function automatic logic [63:0] rand_addr();
    int sel;
    sel = int'($urandom_range(0, 15));
    if (sel < 12) return 64'($urandom_range(0, 5)) << 3;
    if (sel == 12) return (64'($urandom_range(0, 5)) << 3) + 64'($urandom_range(1, 7));
    if (sel == 13) return 64'hF8;
    if (sel == 14) return 64'h100 + (64'($urandom_range(0, 3)) << 3);
    return 64'hFFFF_FFFF_FFFF_FFF8;
  endfunction

  initial begin
    reset = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < int'(WORDS); i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (2) @(negedge im_clk);
    preload = 1'b0;
    reset = 1'b0;
    #1;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_sb_empty", sb_empty, 1'b1);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk64("rst_mem_addr", mem_addr, 64'h0);
    chk64("rst_rsp_rdata", rsp_rdata, 64'h0);
    @(negedge im_clk);

    // Load miss to word 3: read issued next cycle, data three cycles after accept.
    cycle(1'b1, 1'b0, 64'h18, 64'h0);
    chk1("miss_mem_read", mem_read, 1'b1);
    chk64("miss_mem_addr", mem_addr, 64'h18);
    idle(1);
    chk1("miss_ready_c3", req_ready, 1'b0);
    chk1("miss_read_drop", mem_read, 1'b0);
    idle(1);
    chk1("miss_rsp_valid", rsp_valid, 1'b1);
    chk64("miss_rsp_rdata", rsp_rdata, 64'h1122);
    chk1("miss_ready_c4", req_ready, 1'b0);
    idle(1);

    // Two stores to one word then a load: youngest data forwarded.
    cycle(1'b1, 1'b1, 64'h20, 64'hAA);
    cycle(1'b1, 1'b1, 64'h20, 64'hBB);
    chk1("fwd_drain_write", mem_write, 1'b1);
    chk64("fwd_drain_data", mem_wdata, 64'hAA);
    cycle(1'b1, 1'b0, 64'h20, 64'h0);
    chk1("fwd_rsp_valid", rsp_valid, 1'b1);
    chk64("fwd_rsp_rdata", rsp_rdata, 64'hBB);
    chk1("fwd_no_read", mem_read, 1'b0);
    idle(3);

    // Error boundaries: misaligned load, first out-of-range word, last valid word.
    cycle(1'b1, 1'b0, 64'h1C, 64'h0);
    chk1("err_mis_err", rsp_err, 1'b1);
    chk1("err_mis_valid", rsp_valid, 1'b1);
    chk1("err_mis_noread", mem_read, 1'b0);
    cycle(1'b1, 1'b1, 64'h100, 64'h77);
    chk1("err_oor_err", rsp_err, 1'b1);
    chk1("err_oor_empty", sb_empty, 1'b1);
    cycle(1'b1, 1'b1, 64'hF8, 64'h99);
    chk1("last_word_err", rsp_err, 1'b0);
    chk1("last_word_buf", sb_empty, 1'b0);
    idle(3);

    // Miss beats drain; later load to the in-flight word is forwarded.
    cycle(1'b1, 1'b1, 64'h08, 64'h5A5A);
    cycle(1'b1, 1'b0, 64'h10, 64'h0);
    chk1("prio_read", mem_read, 1'b1);
    chk1("prio_no_write", mem_write, 1'b0);
    chk1("prio_not_empty", sb_empty, 1'b0);
    idle(2);
    chk64("prio_rsp_rdata", rsp_rdata, 64'h1002);
    idle(1);
    chk1("prio_drain_write", mem_write, 1'b1);
    chk64("prio_drain_addr", mem_addr, 64'h08);
    cycle(1'b1, 1'b0, 64'h08, 64'h0);
    chk64("inflight_fwd", rsp_rdata, 64'h5A5A);
    chk1("inflight_no_read", mem_read, 1'b0);
    idle(3);
    chk64("dmem_word4", dmem[4], 64'hBB);
    chk64("dmem_word1", dmem[1], 64'h5A5A);
    chk64("dmem_word31", dmem[31], 64'h99);

    // Asynchronous reset while the read request is on the port.
    cycle(1'b1, 1'b0, 64'h28, 64'h0);
    chk1("pre_rst_read", mem_read, 1'b1);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk1("async_rst_read", mem_read, 1'b0);
    chk1("async_rst_valid", rsp_valid, 1'b0);
    chk1("async_rst_empty", sb_empty, 1'b1);
    model_reset();
    @(posedge im_clk);
    @(negedge im_clk);
    reset = 1'b0;
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 2500; n++) begin
      cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), rand_addr(),
            {$urandom, $urandom});
    end
    idle(10);
    for (int i = 0; i < int'(WORDS); i++) chk64("dmem_final", dmem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator side of the data-memory interface. Sits between the MEM-stage load/store requester and data_mem.
- Accepts LDUR/STUR requests and drives mem_read/mem_write/address/write-data toward data_mem. Captures data_mem's registered read data and returns responses.
- Holds posted stores in a small store buffer that drains when the port is free. Loads that hit the buffer are forwarded without a memory access.

Parameters:
- SB_DEPTH, 4, store-buffer entries (power of 2, ≥2).
- MEM_WORDS, 32, addressable 64-bit words in data_mem; word index = addr/8.

Ports:
- im_clk  in  1  clock (all logic on posedge).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_write  in  1  1=store, 0=load.
- req_addr  in  `WORD  byte address (alu_result).
- req_wdata  in  `WORD  store data (read_data2).
- rsp_valid  out  1  one-cycle response pulse; no back-pressure.
- rsp_rdata  out  `WORD  load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or out-of-range access.
- mem_read  out  1  to data_mem.
- mem_write  out  1  to data_mem.
- mem_addr  out  `WORD  to data_mem address (word-aligned byte address).
- mem_wdata  out  `WORD  to data_mem write data.
- mem_rdata  in  `WORD  from data_mem read_data (registered in data_mem).
- sb_empty  out  1  store buffer and in-flight write register both empty (used for fence/halt).

Behaviour:
- Reset (async, any state): state=IDLE, buffer empty, in-flight write cleared. mem_read=mem_write=0, mem_addr=mem_wdata=0. rsp_valid=rsp_err=0, rsp_rdata=0. req_ready=1 after release, sb_empty=1. Pending load and buffered stores are discarded.
- All mem_* outputs are registered.
- Error check at accept: addr[2:0]!=0 or addr/8 ≥ MEM_WORDS sets err. Response is rsp_valid=1, rsp_err=1 on the next cycle. No memory access and no buffer entry.
- FSM states: IDLE, RD_REQ, RD_DATA.
- IDLE, req_ready:
  - For loads: req_ready=1.
  - For stores: req_ready=!full. There is no pass-through while full, even if a pop happens the same cycle.
- Store accept: push {addr, wdata} at the tail. Ack on the next cycle: rsp_valid=1, rsp_err=0, rsp_rdata=0. There is no merge; duplicate addresses occupy separate entries.
- Load accept, hit:
  - The address is compared against all valid buffer entries and the in-flight write register.
  - On a match, the youngest matching data is returned: rsp_valid=1 with rsp_rdata the next cycle. No memory access; state stays IDLE.
- Load accept, miss: on accept edge N, register mem_read=1, mem_addr=addr; state→RD_REQ.
  - Cycle N+1 (RD_REQ): mem_read high; data_mem samples. Register mem_read=0; state→RD_DATA; req_ready=0.
  - Cycle N+2 (RD_DATA): mem_rdata valid; register into rsp_rdata; state→IDLE; req_ready=0.
  - Cycle N+3: rsp_valid=1. Miss latency is therefore 3 cycles accept→response.
- Drain:
  - In IDLE, if the buffer is non-empty and no load miss is accepted this edge, pop the head into the in-flight write register and register mem_write=1, mem_addr, mem_wdata.
  - mem_write is high exactly one cycle; the in-flight register clears after that cycle.
  - A load miss has priority over drain in the same cycle.
  - mem_read and mem_write are never high together.
- Simultaneous push and pop: both proceed, and the count is unchanged. Pointers wrap modulo SB_DEPTH; full/empty are derived from a count of width clog2(SB_DEPTH)+1.
- No drain occurs in RD_REQ/RD_DATA. Stores are not accepted there either, because req_ready=0.
- Ordering: a load miss goes to memory only when no older store to the same word is pending or in flight, so a memory read never bypasses an older store.

Decomposition:
- definitions.vh (shared): `WORD, DMEM_WORDS default, FSM state encodings (IDLE/RD_REQ/RD_DATA), address-check macro.
- Sub-module store_buffer: circular FIFO with push/pop, full/empty/count, and a parallel address compare returning hit plus youngest-match data.
- dmem_access_ctrl holds the FSM, the error check, the in-flight write register and the mem_* registers.

Test Plan:
- Reset then load miss: mem[3]=0x1122 preset, load addr 0x18 accepted at cycle 1 → mem_read=1 with mem_addr=0x18 in cycle 2, rsp_valid=1 with rsp_rdata=0x1122 in cycle 4, req_ready=0 in cycles 3–4.
- Store then forward: store 0x20←0xAA, then store 0x20←0xBB, then load 0x20 on consecutive cycles → load response 0xBB one cycle after accept; mem_read never asserted.
- Fill/drain: with loads held off, 4 stores accepted back-to-back → drain proceeds one pop per cycle while stores are accepted; hold the drain (continuous load misses) until full → req_ready=0 with store pending. After drain, sb_empty=1 and mem[] holds all 4 values in order.
- Errors: load addr 0x1C → rsp_err=1 next cycle, no mem_*; store addr 0x100 (word 32) → rsp_err=1, buffer count unchanged.
- Load-miss priority and ordering: 1 buffered store to 0x08 plus a load miss to 0x10 in the same cycle → mem_read issued first and mem_write to 0x08 after return to IDLE; a load to 0x08 while it is in flight is forwarded from the in-flight register.
- Async reset asserted in RD_REQ → immediately mem_read=0, rsp_valid=0, sb_empty=1; no response after release.
